exception_ctrl: RTL and testbench

EXCEPTION_CTRL -- requirements
Module: exception_ctrl

---
 rtl/exception_ctrl_pkg.sv | 26 ++
 rtl/exception_ctrl_int_synchronizer.sv | 20 ++
 rtl/exception_ctrl.sv | 72 +++++++
 tb/tb_exception_ctrl.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/exception_ctrl_pkg.sv
// exception_ctrl_pkg: exception codes, FSM states and mem_exc bit positions shared with CP0
package exception_ctrl_pkg;
  localparam int CODE_W = 4;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC00380;
  localparam int B_ADES = 7;
  localparam int B_ADEL = 6;
  localparam int B_SYS = 5;
  localparam int B_BP = 4;
  localparam int B_OV = 3;
  localparam int B_RI = 2;
  localparam int B_IF = 1;
  localparam int B_ERET = 0;
  typedef enum logic [CODE_W-1:0] {
    EXC_NONE = 4'd0,
    EXC_INT = 4'd1,
    EXC_IF = 4'd2,
    EXC_ADEL = 4'd3,
    EXC_RI = 4'd4,
    EXC_OV = 4'd5,
    EXC_BP = 4'd6,
    EXC_SYS = 4'd7,
    EXC_ADES = 4'd8,
    EXC_ERET = 4'd9
  } exc_code_t;
  typedef enum logic {S_IDLE, S_REDIRECT} state_t;
endpackage

// File: rtl/exception_ctrl_int_synchronizer.sv
// int_synchronizer: per-bit flop chain of depth D, level pass-through; ports clk, rst, d[W] in, q[W] out
module int_synchronizer #(
  parameter int W = 5,
  parameter int D = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [D-1:0][W-1:0] s;
  always_ff @(posedge clk) begin
    if (rst) s <= '0;
    else begin
      s[0] <= d;
      for (int i = 1; i < D; i++) s[i] <= s[i-1];
    end
  end
  assign q = s[D-1];
endmodule

// File: rtl/exception_ctrl.sv
// exception_ctrl: MEM-stage exception prioritizer and redirect FSM; ports: ext_int/MEM-stage/CP0 in, CP0 event info, flush and redirect handshake out
module exception_ctrl
  import exception_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        ext_int,
  input  logic              mem_valid,
  input  logic [31:0]       mem_pc,
  input  logic              mem_delayslot,
  input  logic [7:0]        mem_exc,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       cp0_status,
  input  logic [31:0]       cp0_cause,
  input  logic [31:0]       cp0_epc,
  output logic [4:0]        int_sync,
  output logic [CODE_W-1:0] exception_type,
  output logic              delayslot_flag,
  output logic [31:0]       current_pc_addr,
  output logic [31:0]       cp0_badvaddr_write_data,
  output logic              flush,
  output logic              redirect_valid,
  output logic [31:0]       redirect_pc,
  input  logic              redirect_ready
);
  state_t state, state_n;
  exc_code_t code;
  logic int_pend, take;
  logic unused_bits;
  assign unused_bits = ^{cp0_status[31:16], cp0_status[7:2], cp0_cause[31:16], cp0_cause[7:0]};
  int_synchronizer #(.W(5), .D(SYNC_STAGES)) u_sync (
    .clk(clk),
    .rst(rst),
    .d(ext_int),
    .q(int_sync)
  );
  always_comb begin
    int_pend = mem_valid & cp0_status[0] & ~cp0_status[1] & |(cp0_cause[15:8] & cp0_status[15:8]);
    code = int_pend ? EXC_INT :
           !mem_valid ? EXC_NONE :
           mem_exc[B_IF] ? EXC_IF :
           mem_exc[B_RI] ? EXC_RI :
           mem_exc[B_OV] ? EXC_OV :
           mem_exc[B_SYS] ? EXC_SYS :
           mem_exc[B_BP] ? EXC_BP :
           mem_exc[B_ADEL] ? EXC_ADEL :
           mem_exc[B_ADES] ? EXC_ADES :
           mem_exc[B_ERET] ? EXC_ERET : EXC_NONE;
    take = !rst && state == S_IDLE && code != EXC_NONE;
    state_n = state == S_IDLE ? (take ? S_REDIRECT : S_IDLE) : (redirect_ready ? S_IDLE : S_REDIRECT);
    exception_type = take ? code : EXC_NONE;
    flush = !rst && (take || state == S_REDIRECT);
    redirect_valid = !rst && state == S_REDIRECT;
    delayslot_flag = mem_delayslot;
    current_pc_addr = mem_pc;
    cp0_badvaddr_write_data = !take ? 32'h0 :
                              code == EXC_IF ? mem_pc :
                              (code == EXC_ADEL || code == EXC_ADES) ? mem_addr : 32'h0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      redirect_pc <= '0;
    end else begin
      state <= state_n;
      if (take) redirect_pc <= code == EXC_ERET ? cp0_epc : EXC_VECTOR;
    end
  end
endmodule

// File: tb/tb_exception_ctrl.sv
// tb_exception_ctrl: directed vectors with hand-computed expectations for exception_ctrl
module tb_exception_ctrl;
  logic clk = 0, rst = 1;
  logic [4:0] ext_int = 0, int_sync;
  logic mem_valid = 0, mem_delayslot = 0, redirect_ready = 0;
  logic [31:0] mem_pc = 0, mem_addr = 0, cp0_status = 0, cp0_cause = 0, cp0_epc = 0;
  logic [7:0] mem_exc = 0;
  logic [3:0] exception_type;
  logic delayslot_flag, flush, redirect_valid;
  logic [31:0] current_pc_addr, cp0_badvaddr_write_data, redirect_pc;
  int n_cmp = 0, n_bad = 0;
  exception_ctrl dut (
    .clk(clk),
    .rst(rst),
    .ext_int(ext_int),
    .mem_valid(mem_valid),
    .mem_pc(mem_pc),
    .mem_delayslot(mem_delayslot),
    .mem_exc(mem_exc),
    .mem_addr(mem_addr),
    .cp0_status(cp0_status),
    .cp0_cause(cp0_cause),
    .cp0_epc(cp0_epc),
    .int_sync(int_sync),
    .exception_type(exception_type),
    .delayslot_flag(delayslot_flag),
    .current_pc_addr(current_pc_addr),
    .cp0_badvaddr_write_data(cp0_badvaddr_write_data),
    .flush(flush),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    tick();
    tick();
    chk("rst_type", exception_type, 0);
    chk("rst_flush", flush, 0);
    chk("rst_rv", redirect_valid, 0);
    chk("rst_rpc", redirect_pc, 0);
    chk("rst_sync", int_sync, 0);
    rst = 0;
    mem_valid = 1; mem_exc = 8'h28; mem_pc = 32'h80001000; mem_delayslot = 1;
    #1;
    chk("ov_type", exception_type, 5);
    chk("ov_ds", delayslot_flag, 1);
    chk("ov_flush", flush, 1);
    chk("ov_pc", current_pc_addr, 32'h80001000);
    chk("ov_bad", cp0_badvaddr_write_data, 0);
    chk("ov_rv_idle", redirect_valid, 0);
    tick();
    chk("ov_rpc", redirect_pc, 32'hBFC00380);
    chk("ov_rv", redirect_valid, 1);
    chk("ov_rflush", flush, 1);
    chk("ov_rtype", exception_type, 0);
    redirect_ready = 1;
    tick();
    mem_valid = 0; redirect_ready = 0; mem_delayslot = 0;
    #1;
    chk("ov_idle_rv", redirect_valid, 0);
    chk("ov_idle_flush", flush, 0);
    cp0_status = 32'h403; cp0_cause = 32'h400; mem_valid = 1; mem_exc = 8'h00;
    #1;
    chk("exl_mask", exception_type, 0);
    cp0_status = 32'h401; mem_exc = 8'h04;
    #1;
    chk("int_over_ri", exception_type, 1);
    tick();
    chk("int_supp", exception_type, 0);
    redirect_ready = 1;
    tick();
    chk("int_retake", exception_type, 1);
    mem_valid = 0; cp0_status = 0; cp0_cause = 0;
    tick();
    tick();
    redirect_ready = 0;
    mem_valid = 1; mem_exc = 8'h01; cp0_epc = 32'h80002000;
    #1;
    chk("eret_type", exception_type, 9);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("eret_rv_hold", redirect_valid, 1);
      chk("eret_rpc", redirect_pc, 32'h80002000);
      tick();
    end
    redirect_ready = 1;
    tick();
    mem_valid = 0; redirect_ready = 0;
    #1;
    chk("eret_idle", redirect_valid, 0);
    chk("eret_rpc_keep", redirect_pc, 32'h80002000);
    mem_valid = 1; mem_exc = 8'h80; mem_addr = 32'h80000003;
    #1;
    chk("ades_type", exception_type, 8);
    chk("ades_bad", cp0_badvaddr_write_data, 32'h80000003);
    tick();
    mem_exc = 8'h02;
    #1;
    chk("redir_supp", exception_type, 0);
    chk("redir_bad0", cp0_badvaddr_write_data, 0);
    chk("ades_rpc", redirect_pc, 32'hBFC00380);
    rst = 1;
    tick();
    chk("rr_type", exception_type, 0);
    chk("rr_flush", flush, 0);
    chk("rr_rv", redirect_valid, 0);
    chk("rr_rpc", redirect_pc, 0);
    rst = 0; mem_valid = 0;
    #1;
    chk("rr_idle_rv", redirect_valid, 0);
    mem_valid = 1; mem_exc = 8'h50;
    #1;
    chk("bp_over_adel", exception_type, 6);
    mem_exc = 8'h42; mem_pc = 32'h80004444;
    #1;
    chk("if_type", exception_type, 2);
    chk("if_bad", cp0_badvaddr_write_data, 32'h80004444);
    mem_exc = 8'h81;
    #1;
    chk("ades_over_eret", exception_type, 8);
    mem_exc = 8'h40; mem_addr = 32'h80000005;
    #1;
    chk("adel_bad", cp0_badvaddr_write_data, 32'h80000005);
    mem_valid = 0;
    #1;
    chk("novalid", exception_type, 0);
    ext_int = 5'h04;
    tick();
    chk("sync_1", int_sync, 0);
    tick();
    chk("sync_2", int_sync, 5'h04);
    ext_int = 0;
    tick();
    chk("sync_hold", int_sync, 5'h04);
    tick();
    chk("sync_clr", int_sync, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
